// File: rtl/connect4_pkg.sv
// connect4_pkg
// Shared definitions for the Connect4 turn controller: the turn FSM state
// encoding, the board's placement result codes and the default board width.
// No ports; imported by the controller top.
package connect4_pkg;

  // Turn sequencing states
  typedef enum logic [1:0] {
    SELECT = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    OVER   = 2'd3
  } state_t;

  // Placement result codes returned by the board alongside result_valid
  localparam logic [1:0] RES_PLACED   = 2'b00;
  localparam logic [1:0] RES_WIN      = 2'b01;
  localparam logic [1:0] RES_DRAW     = 2'b10;
  localparam logic [1:0] RES_COL_FULL = 2'b11;

  // Standard Connect4 board width
  localparam int NUM_COLS_DEFAULT = 7;

endpackage

// File: rtl/button_press_pulse.sv
// button_press_pulse
// Qualifies one raw active-low push button (already synchronised to i_clk).
// A counter runs while the button is low and clears the first cycle it reads
// high. A one-cycle pulse fires on the cycle the count reaches
// DEBOUNCE_CYCLES; with REPEAT_EN set, further pulses follow every
// REPEAT_CYCLES while the button stays held.
//
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset, clears the counters
//   i_btn_n  raw button, active-low
//   o_pulse  one-cycle press (and auto-repeat) pulse
module button_press_pulse #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_n,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic [CW-1:0] r_count;
  logic [RW-1:0] r_rep;
  logic          w_low;
  logic          w_held;
  logic          w_first;
  logic          w_repeat;

  // The pulse is decoded from the count that is about to be reached, so it
  // appears in the same cycle as the DEBOUNCE_CYCLES-th low sample.
  assign w_low    = ~i_btn_n;
  assign w_held   = (r_count == CW'(DEBOUNCE_CYCLES));
  assign w_first  = w_low && (r_count == CW'(DEBOUNCE_CYCLES - 1));
  assign w_repeat = REPEAT_EN && w_low && w_held &&
                    (r_rep == RW'(REPEAT_CYCLES - 1));
  assign o_pulse  = w_first || w_repeat;

  // Debounce count saturates once the press is accepted; the repeat counter
  // then takes over and wraps at each auto-repeat pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset || !w_low) begin
      r_count <= '0;
      r_rep   <= '0;
    end else if (!w_held) begin
      r_count <= r_count + CW'(1);
      r_rep   <= '0;
    end else if (w_repeat) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + RW'(1);
    end
  end

endmodule

// File: rtl/connect4_turn_controller.sv
// connect4_turn_controller
// Sequences a two-player Connect4 game from three raw push buttons: moves a
// column cursor, issues drop requests to the board over valid/ready, consumes
// the board's placement result, then alternates players or ends the game.
//
// Ports:
//   i_clk, i_reset                          clock, synchronous active-high reset
//   i_btn_left_n/right_n/drop_n             raw active-low buttons
//   o_cursor_col, o_cur_player              selected column, player to move
//   o_drop_valid, o_drop_col, o_drop_player drop request to the board
//   i_drop_ready                            board accepts the request
//   i_result_valid, i_result_code           placement result strobe
//   o_game_over, o_winner, o_draw           end-of-game status
//   o_new_game                              one-cycle board clear pulse
module connect4_turn_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter int NUM_COLS        = connect4_pkg::NUM_COLS_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_left_n,
  input  logic       i_btn_right_n,
  input  logic       i_btn_drop_n,
  output logic [2:0] o_cursor_col,
  output logic       o_cur_player,
  output logic       o_drop_valid,
  output logic [2:0] o_drop_col,
  output logic       o_drop_player,
  input  logic       i_drop_ready,
  input  logic       i_result_valid,
  input  logic [1:0] i_result_code,
  output logic       o_game_over,
  output logic       o_winner,
  output logic       o_draw,
  output logic       o_new_game
);

  import connect4_pkg::*;

  localparam logic [2:0] COL_CENTER = 3'(NUM_COLS / 2);
  localparam logic [2:0] COL_MAX    = 3'(NUM_COLS - 1);

  logic       w_left;
  logic       w_right;
  logic       w_drop;

  state_t     r_state;
  logic [2:0] r_cursor_col;
  logic       r_cur_player;
  logic       r_drop_valid;
  logic [2:0] r_drop_col;
  logic       r_drop_player;
  logic       r_game_over;
  logic       r_winner;
  logic       r_draw;
  logic       r_new_game;

  button_press_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b1)
  ) u_left (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn_n(i_btn_left_n),
    .o_pulse(w_left)
  );

  button_press_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b1)
  ) u_right (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn_n(i_btn_right_n),
    .o_pulse(w_right)
  );

  // Drop never auto-repeats: one request per physical press.
  button_press_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (1'b0)
  ) u_drop (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn_n(i_btn_drop_n),
    .o_pulse(w_drop)
  );

  // Turn FSM with all outputs held in registers. Button pulses only act in
  // SELECT (and drop in OVER); anything arriving while a request or result is
  // outstanding is simply dropped. A drop coinciding with a move latches the
  // pre-move column because the move branch is skipped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= SELECT;
      r_cursor_col  <= COL_CENTER;
      r_cur_player  <= 1'b0;
      r_drop_valid  <= 1'b0;
      r_drop_col    <= 3'd0;
      r_drop_player <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
      r_draw        <= 1'b0;
      r_new_game    <= 1'b0;
    end else begin
      r_new_game <= 1'b0;
      case (r_state)
        SELECT: begin
          if (w_drop) begin
            r_drop_valid  <= 1'b1;
            r_drop_col    <= r_cursor_col;
            r_drop_player <= r_cur_player;
            r_state       <= REQ;
          end else if (w_left && !w_right && (r_cursor_col != 3'd0)) begin
            r_cursor_col <= r_cursor_col - 3'd1;
          end else if (w_right && !w_left && (r_cursor_col != COL_MAX)) begin
            r_cursor_col <= r_cursor_col + 3'd1;
          end
        end
        REQ: begin
          if (i_drop_ready) begin
            r_drop_valid <= 1'b0;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (i_result_valid) begin
            case (i_result_code)
              RES_PLACED: begin
                r_cur_player <= ~r_cur_player;
                r_cursor_col <= COL_CENTER;
                r_state      <= SELECT;
              end
              RES_WIN: begin
                r_game_over <= 1'b1;
                r_winner    <= r_drop_player;
                r_state     <= OVER;
              end
              RES_DRAW: begin
                r_game_over <= 1'b1;
                r_draw      <= 1'b1;
                r_state     <= OVER;
              end
              RES_COL_FULL: begin
                r_state <= SELECT;
              end
            endcase
          end
        end
        OVER: begin
          if (w_drop) begin
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
            r_draw       <= 1'b0;
            r_new_game   <= 1'b1;
            r_cur_player <= 1'b0;
            r_cursor_col <= COL_CENTER;
            r_state      <= SELECT;
          end
        end
        default: r_state <= SELECT;
      endcase
    end
  end

  assign o_cursor_col  = r_cursor_col;
  assign o_cur_player  = r_cur_player;
  assign o_drop_valid  = r_drop_valid;
  assign o_drop_col    = r_drop_col;
  assign o_drop_player = r_drop_player;
  assign o_game_over   = r_game_over;
  assign o_winner      = r_winner;
  assign o_draw        = r_draw;
  assign o_new_game    = r_new_game;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// tb_connect4_turn_controller
// Self-checking bench for connect4_turn_controller with short debounce and
// repeat times. Expected values are queued as stimulus is applied and popped
// when the corresponding output is sampled, one cycle-accurate step at a time.
module tb_connect4_turn_controller;

  logic       clk;
  logic       reset;
  logic       btnLeftN;
  logic       btnRightN;
  logic       btnDropN;
  logic [2:0] cursorCol;
  logic       curPlayer;
  logic       dropValid;
  logic [2:0] dropCol;
  logic       dropPlayer;
  logic       dropReady;
  logic       resultValid;
  logic [1:0] resultCode;
  logic       gameOver;
  logic       winner;
  logic       draw;
  logic       newGame;

  int compared   = 0;
  int mismatched = 0;
  int expQ[$];
  int exp;

  connect4_turn_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8),
    .NUM_COLS       (7)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_btn_left_n  (btnLeftN),
    .i_btn_right_n (btnRightN),
    .i_btn_drop_n  (btnDropN),
    .o_cursor_col  (cursorCol),
    .o_cur_player  (curPlayer),
    .o_drop_valid  (dropValid),
    .o_drop_col    (dropCol),
    .o_drop_player (dropPlayer),
    .i_drop_ready  (dropReady),
    .i_result_valid(resultValid),
    .i_result_code (resultCode),
    .o_game_over   (gameOver),
    .o_winner      (winner),
    .o_draw        (draw),
    .o_new_game    (newGame)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the chosen buttons low for n cycles, then release all of them
  task automatic holdButtons(input bit l, input bit r, input bit d, input int n);
    btnLeftN  = ~l;
    btnRightN = ~r;
    btnDropN  = ~d;
    repeat (n) tick();
    btnLeftN  = 1'b1;
    btnRightN = 1'b1;
    btnDropN  = 1'b1;
  endtask

  // Present a one-cycle result strobe
  task automatic sendResult(input logic [1:0] code);
    resultValid = 1'b1;
    resultCode  = code;
    tick();
    resultValid = 1'b0;
    resultCode  = 2'b00;
  endtask

  // Reset values of every output
  task automatic test_reset();
    reset = 1'b1;
    expQ.push_back(3); expQ.push_back(0); expQ.push_back(0); expQ.push_back(0);
    expQ.push_back(0); expQ.push_back(0); expQ.push_back(0); expQ.push_back(0);
    expQ.push_back(0);
    tick(); tick();
    reset = 1'b0;
    tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL reset_cursor: got %0d want %0d", cursorCol, exp); end
    exp = expQ.pop_front(); compared++;
    if (curPlayer !== 1'(exp)) begin mismatched++; $display("[TB] FAIL reset_player: got %0d want %0d", curPlayer, exp); end
    exp = expQ.pop_front(); compared++;
    if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL reset_drop_valid: got %0d want %0d", dropValid, exp); end
    exp = expQ.pop_front(); compared++;
    if (dropCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL reset_drop_col: got %0d want %0d", dropCol, exp); end
    exp = expQ.pop_front(); compared++;
    if (dropPlayer !== 1'(exp)) begin mismatched++; $display("[TB] FAIL reset_drop_player: got %0d want %0d", dropPlayer, exp); end
    exp = expQ.pop_front(); compared++;
    if (gameOver !== 1'(exp)) begin mismatched++; $display("[TB] FAIL reset_game_over: got %0d want %0d", gameOver, exp); end
    exp = expQ.pop_front(); compared++;
    if (winner !== 1'(exp)) begin mismatched++; $display("[TB] FAIL reset_winner: got %0d want %0d", winner, exp); end
    exp = expQ.pop_front(); compared++;
    if (draw !== 1'(exp)) begin mismatched++; $display("[TB] FAIL reset_draw: got %0d want %0d", draw, exp); end
    exp = expQ.pop_front(); compared++;
    if (newGame !== 1'(exp)) begin mismatched++; $display("[TB] FAIL reset_new_game: got %0d want %0d", newGame, exp); end
  endtask

  // Short press rejected, full-length press moves exactly at t+4
  task automatic test_bounce();
    expQ.push_back(3);
    holdButtons(1'b0, 1'b1, 1'b0, 3);
    tick(); tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL bounce_short: got %0d want %0d", cursorCol, exp); end

    btnRightN = 1'b0;
    expQ.push_back(3);
    expQ.push_back(4);
    repeat (3) tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL bounce_t3: got %0d want %0d", cursorCol, exp); end
    tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL bounce_t4: got %0d want %0d", cursorCol, exp); end
    btnRightN = 1'b1;
    tick();
  endtask

  // Auto-repeat timing, saturation at the right edge, simultaneous left+right
  task automatic test_saturation();
    btnRightN = 1'b0;
    expQ.push_back(5);
    repeat (4) tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL repeat_first: got %0d want %0d", cursorCol, exp); end
    expQ.push_back(5);
    repeat (7) tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL repeat_early: got %0d want %0d", cursorCol, exp); end
    expQ.push_back(6);
    tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL repeat_second: got %0d want %0d", cursorCol, exp); end
    for (int k = 0; k < 4; k++) begin
      expQ.push_back(6);
      repeat (8) tick();
      exp = expQ.pop_front(); compared++;
      if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL repeat_saturate%0d: got %0d want %0d", k, cursorCol, exp); end
    end
    btnRightN = 1'b1;
    tick();

    expQ.push_back(5);
    holdButtons(1'b1, 1'b0, 1'b0, 4);
    tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL left_step: got %0d want %0d", cursorCol, exp); end

    expQ.push_back(5);
    holdButtons(1'b1, 1'b1, 1'b0, 4);
    tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL left_right_together: got %0d want %0d", cursorCol, exp); end

    expQ.push_back(2);
    for (int k = 0; k < 3; k++) begin
      holdButtons(1'b1, 1'b0, 1'b0, 4);
      tick();
    end
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL left_to_col2: got %0d want %0d", cursorCol, exp); end
  endtask

  // Request held stable under backpressure, then placed result
  task automatic test_handshake();
    dropReady = 1'b0;
    btnDropN  = 1'b0;
    repeat (4) tick();
    btnDropN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expQ.push_back(1); expQ.push_back(2); expQ.push_back(0);
      exp = expQ.pop_front(); compared++;
      if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL hs_valid%0d: got %0d want %0d", k, dropValid, exp); end
      exp = expQ.pop_front(); compared++;
      if (dropCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL hs_col%0d: got %0d want %0d", k, dropCol, exp); end
      exp = expQ.pop_front(); compared++;
      if (dropPlayer !== 1'(exp)) begin mismatched++; $display("[TB] FAIL hs_player%0d: got %0d want %0d", k, dropPlayer, exp); end
      tick();
    end
    dropReady = 1'b1;
    expQ.push_back(1);
    exp = expQ.pop_front(); compared++;
    if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL hs_valid_at_handshake: got %0d want %0d", dropValid, exp); end
    expQ.push_back(0);
    tick();
    dropReady = 1'b0;
    exp = expQ.pop_front(); compared++;
    if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL hs_valid_fall: got %0d want %0d", dropValid, exp); end

    expQ.push_back(1); expQ.push_back(3);
    sendResult(2'b00);
    exp = expQ.pop_front(); compared++;
    if (curPlayer !== 1'(exp)) begin mismatched++; $display("[TB] FAIL placed_player: got %0d want %0d", curPlayer, exp); end
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL placed_cursor: got %0d want %0d", cursorCol, exp); end
  endtask

  // Ready already high, column-full result, re-issue on the same column
  task automatic test_col_full();
    dropReady = 1'b1;
    btnDropN  = 1'b0;
    expQ.push_back(1); expQ.push_back(3); expQ.push_back(1); expQ.push_back(0);
    repeat (4) tick();
    btnDropN = 1'b1;
    exp = expQ.pop_front(); compared++;
    if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL cf_valid: got %0d want %0d", dropValid, exp); end
    exp = expQ.pop_front(); compared++;
    if (dropCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL cf_col: got %0d want %0d", dropCol, exp); end
    exp = expQ.pop_front(); compared++;
    if (dropPlayer !== 1'(exp)) begin mismatched++; $display("[TB] FAIL cf_player: got %0d want %0d", dropPlayer, exp); end
    tick();
    dropReady = 1'b0;
    exp = expQ.pop_front(); compared++;
    if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL cf_fast_handshake: got %0d want %0d", dropValid, exp); end

    expQ.push_back(1); expQ.push_back(3);
    sendResult(2'b11);
    exp = expQ.pop_front(); compared++;
    if (curPlayer !== 1'(exp)) begin mismatched++; $display("[TB] FAIL cf_player_kept: got %0d want %0d", curPlayer, exp); end
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL cf_cursor_kept: got %0d want %0d", cursorCol, exp); end

    expQ.push_back(1); expQ.push_back(3);
    holdButtons(1'b0, 1'b0, 1'b1, 4);
    exp = expQ.pop_front(); compared++;
    if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL cf_reissue_valid: got %0d want %0d", dropValid, exp); end
    exp = expQ.pop_front(); compared++;
    if (dropCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL cf_reissue_col: got %0d want %0d", dropCol, exp); end
    dropReady = 1'b1;
    tick();
    dropReady = 1'b0;
  endtask

  // Win for player 2, ignored move, restart pulse; then a drawn game
  task automatic test_win_restart();
    expQ.push_back(1); expQ.push_back(1); expQ.push_back(0);
    sendResult(2'b01);
    exp = expQ.pop_front(); compared++;
    if (gameOver !== 1'(exp)) begin mismatched++; $display("[TB] FAIL win_game_over: got %0d want %0d", gameOver, exp); end
    exp = expQ.pop_front(); compared++;
    if (winner !== 1'(exp)) begin mismatched++; $display("[TB] FAIL win_winner: got %0d want %0d", winner, exp); end
    exp = expQ.pop_front(); compared++;
    if (draw !== 1'(exp)) begin mismatched++; $display("[TB] FAIL win_draw: got %0d want %0d", draw, exp); end

    expQ.push_back(3); expQ.push_back(1);
    holdButtons(1'b1, 1'b0, 1'b0, 4);
    tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL over_left_ignored: got %0d want %0d", cursorCol, exp); end
    exp = expQ.pop_front(); compared++;
    if (gameOver !== 1'(exp)) begin mismatched++; $display("[TB] FAIL over_still: got %0d want %0d", gameOver, exp); end

    expQ.push_back(1); expQ.push_back(0); expQ.push_back(0); expQ.push_back(0);
    holdButtons(1'b0, 1'b0, 1'b1, 4);
    exp = expQ.pop_front(); compared++;
    if (newGame !== 1'(exp)) begin mismatched++; $display("[TB] FAIL restart_new_game: got %0d want %0d", newGame, exp); end
    exp = expQ.pop_front(); compared++;
    if (gameOver !== 1'(exp)) begin mismatched++; $display("[TB] FAIL restart_game_over: got %0d want %0d", gameOver, exp); end
    exp = expQ.pop_front(); compared++;
    if (winner !== 1'(exp)) begin mismatched++; $display("[TB] FAIL restart_winner: got %0d want %0d", winner, exp); end
    exp = expQ.pop_front(); compared++;
    if (curPlayer !== 1'(exp)) begin mismatched++; $display("[TB] FAIL restart_player: got %0d want %0d", curPlayer, exp); end
    expQ.push_back(0);
    tick();
    exp = expQ.pop_front(); compared++;
    if (newGame !== 1'(exp)) begin mismatched++; $display("[TB] FAIL restart_pulse_width: got %0d want %0d", newGame, exp); end

    dropReady = 1'b1;
    holdButtons(1'b0, 1'b0, 1'b1, 4);
    tick();
    dropReady = 1'b0;
    expQ.push_back(1); expQ.push_back(1);
    sendResult(2'b10);
    exp = expQ.pop_front(); compared++;
    if (gameOver !== 1'(exp)) begin mismatched++; $display("[TB] FAIL draw_game_over: got %0d want %0d", gameOver, exp); end
    exp = expQ.pop_front(); compared++;
    if (draw !== 1'(exp)) begin mismatched++; $display("[TB] FAIL draw_flag: got %0d want %0d", draw, exp); end
    expQ.push_back(0);
    holdButtons(1'b0, 1'b0, 1'b1, 4);
    tick();
    exp = expQ.pop_front(); compared++;
    if (draw !== 1'(exp)) begin mismatched++; $display("[TB] FAIL draw_cleared: got %0d want %0d", draw, exp); end
  endtask

  // Reset abandons an in-flight request; stray result ignored afterwards
  task automatic test_reset_mid_req();
    dropReady = 1'b0;
    expQ.push_back(1);
    holdButtons(1'b0, 1'b0, 1'b1, 4);
    exp = expQ.pop_front(); compared++;
    if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL midreq_valid: got %0d want %0d", dropValid, exp); end
    reset = 1'b1;
    expQ.push_back(0);
    tick();
    reset = 1'b0;
    exp = expQ.pop_front(); compared++;
    if (dropValid !== 1'(exp)) begin mismatched++; $display("[TB] FAIL midreq_reset_valid: got %0d want %0d", dropValid, exp); end

    expQ.push_back(0); expQ.push_back(3);
    sendResult(2'b01);
    exp = expQ.pop_front(); compared++;
    if (gameOver !== 1'(exp)) begin mismatched++; $display("[TB] FAIL stray_result_game_over: got %0d want %0d", gameOver, exp); end
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL stray_result_cursor: got %0d want %0d", cursorCol, exp); end

    expQ.push_back(4);
    holdButtons(1'b0, 1'b1, 1'b0, 4);
    tick();
    exp = expQ.pop_front(); compared++;
    if (cursorCol !== 3'(exp)) begin mismatched++; $display("[TB] FAIL midreq_back_in_select: got %0d want %0d", cursorCol, exp); end
  endtask

  initial begin
    reset       = 1'b1;
    btnLeftN    = 1'b1;
    btnRightN   = 1'b1;
    btnDropN    = 1'b1;
    dropReady   = 1'b0;
    resultValid = 1'b0;
    resultCode  = 2'b00;
    #1;
    test_reset();
    test_bounce();
    test_saturation();
    test_handshake();
    test_col_full();
    test_win_restart();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
